// File: rtl/store_data_translator_if.sv
// Store-issue and data-memory write channels of the store data translator.
//   st_*  : CPU store request (valid/ready) plus one-cycle misalignment flag
//   mem_* : buffered, lane-steered word write toward data memory (valid/ready)
// slave  : the translator's view (consumes stores, produces memory writes)
// master : the surrounding CPU/memory view
interface store_data_translator_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              st_err;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_data_translator.sv
// Store data translator: steers byte/half/word store data onto big-endian
// byte lanes of a 32-bit word, builds byte enables, drops misaligned stores
// (flagging st_err for one cycle) and buffers aligned writes in a DEPTH-entry
// FIFO that drains to data memory.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : store request and memory write channels (slave modport)
//   count       : entries currently buffered

// One byte lane. LANE 0 is bits [7:0]; big-endian byte offset k lands on
// lane 3-k.
module sdt_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic [31:0] data,
  output logic [7:0]  lane_byte,
  output logic        lane_be
);
  localparam logic [1:0] BYTE_OFS = 2'(3 - LANE);
  localparam logic       LOW_HALF = (LANE < 2);

  always_comb begin
    lane_byte = data[8*LANE +: 8];
    lane_be   = 1'b1;
    case (size)
      2'b11: begin
        lane_byte = data[7:0];
        lane_be   = (ofs == BYTE_OFS);
      end
      2'b01: begin
        lane_byte = data[8*(LANE%2) +: 8];
        lane_be   = (ofs[1] == LOW_HALF);
      end
      default: ;
    endcase
  end
endmodule

module store_data_translator #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  store_data_translator_if.slave bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-3:0] waddr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } entry_t;

  entry_t          buf_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [3:0][7:0] lane_data;
  logic [3:0]      lane_be;
  logic            misaligned, accept, push, pop;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sdt_lane #(.LANE(i)) u_lane (
      .size      (bus.st_size),
      .ofs       (bus.st_addr[1:0]),
      .data      (bus.st_data),
      .lane_byte (lane_data[i]),
      .lane_be   (lane_be[i])
    );
  end

  // Bytes can never be misaligned; sizes 00 and 10 are both words.
  assign misaligned = (bus.st_size == 2'b01 && bus.st_addr[0]) ||
                      (!bus.st_size[0] && bus.st_addr[1:0] != 2'b00);

  // Readiness looks only at occupancy, so a full buffer stays closed even
  // when memory pops in the same cycle.
  assign bus.st_ready  = (count < CW'(DEPTH));
  assign bus.mem_valid = (count != '0);
  assign accept        = bus.st_valid && bus.st_ready;
  assign push          = accept && !misaligned;
  assign pop           = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bus.st_err <= 1'b0;
    end else begin
      bus.st_err <= accept && misaligned;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload needs no reset: it is only visible while mem_valid is set.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= '{waddr: bus.st_addr[ADDR_W-1:2],
                                 wdata: lane_data, be: lane_be};
  end

  assign head          = buf_q[rd_ptr];
  assign bus.mem_addr  = bus.mem_valid ? {head.waddr, 2'b00} : '0;
  assign bus.mem_wdata = bus.mem_valid ? head.wdata : '0;
  assign bus.mem_be    = bus.mem_valid ? head.be : '0;
endmodule

// File: tb/tb_store_data_translator.sv
// Self-checking bench for store_data_translator: directed scenarios plus a
// randomized run compared against a byte-address reference model.
module tb_store_data_translator;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic resetn;
  logic [$clog2(DEPTH):0] count;
  always #5 clk = ~clk;

  store_data_translator_if #(.ADDR_W(ADDR_W)) bus ();

  store_data_translator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .count  (count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  bit   err_exp;
  int   total = 0;
  int   bad   = 0;

  // Reference: a store of n bytes places its bytes at addresses a..a+n-1,
  // most significant byte first; address k sits on lane 3-(k mod 4). The
  // value is replicated across the whole word.
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, output bit mis,
                                output exp_t e);
    int n;
    n = (sz == 2'b11) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis    = (a % n) != 0;
    e.addr = a - (a % 4);
    e.be   = '0;
    for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = d[8*(j % n) +: 8];
    for (int k = 0; k < n; k++) e.be[3 - ((a + k) % 4)] = 1'b1;
  endfunction

  // Drive one cycle (called just after a rising edge), advance the model.
  task automatic step(input bit sv, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit mr);
    bit acc, pp, mis;
    exp_t e;
    bus.st_valid  = sv;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_size   = sz;
    bus.mem_ready = mr;
    acc = sv && (q.size() < DEPTH);
    pp  = mr && (q.size() != 0);
    model(a, d, sz, mis, e);
    @(posedge clk); #1;
    if (pp) q.delete(0);
    err_exp = acc && mis;
    if (acc && !mis) q.push_back(e);
    bus.st_valid  = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    q.delete();
    err_exp = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_size = 0;
    bus.mem_ready = 0;
    repeat (2) @(posedge clk); #1;
    total++; if (count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (bus.mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid); end
    total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL reset_st_err got=%b exp=0", bus.st_err); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin bad++;
      $display("FAIL reset_mem_bus got=%h/%h/%b exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready got=%b exp=1", bus.st_ready); end
    resetn = 1'b1;
    q.delete();
    err_exp = 1'b0;
  endtask

  task automatic test_byte();
    step(1, 32'h1001, 32'h0000_00A5, 2'b11, 0);
    total++; if (bus.mem_valid !== 1'b1 || count !== 1) begin bad++;
      $display("FAIL byte_valid got=%b/%0d exp=1/1", bus.mem_valid, count); end
    total++; if (bus.mem_addr !== 32'h1000) begin bad++; $display("FAIL byte_addr got=%h exp=1000", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byte_wdata got=%h exp=a5a5a5a5", bus.mem_wdata); end
    total++; if (bus.mem_be !== 4'b0100) begin bad++; $display("FAIL byte_be got=%b exp=0100", bus.mem_be); end
    step(0, 0, 0, 0, 1);
    total++; if (count !== 0 || bus.mem_valid !== 1'b0) begin bad++;
      $display("FAIL byte_drain got=%0d/%b exp=0/0", count, bus.mem_valid); end
  endtask

  task automatic test_half_word();
    step(1, 32'h2002, 32'h1234_BEEF, 2'b01, 0);
    step(1, 32'h3000, 32'hDEAD_BEEF, 2'b00, 0);
    total++; if (count !== 2) begin bad++; $display("FAIL hw_count got=%0d exp=2", count); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h2000, 32'hBEEF_BEEF, 4'b0011}) begin bad++;
      $display("FAIL hw_half got=%h/%h/%b exp=2000/beefbeef/0011", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    step(0, 0, 0, 0, 1);
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h3000, 32'hDEAD_BEEF, 4'b1111}) begin bad++;
      $display("FAIL hw_word got=%h/%h/%b exp=3000/deadbeef/1111", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    step(0, 0, 0, 0, 1);
    total++; if (count !== 0) begin bad++; $display("FAIL hw_drain got=%0d exp=0", count); end
  endtask

  task automatic test_misaligned();
    step(1, 32'h4001, 32'h1111_2222, 2'b01, 0);
    total++; if (bus.st_err !== 1'b1 || count !== 0 || bus.mem_valid !== 1'b0) begin bad++;
      $display("FAIL mis_half got=%b/%0d/%b exp=1/0/0", bus.st_err, count, bus.mem_valid); end
    step(0, 0, 0, 0, 0);
    total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", bus.st_err); end
    step(1, 32'h4002, 32'h3333_4444, 2'b00, 0);
    total++; if (bus.st_err !== 1'b1 || count !== 0) begin bad++;
      $display("FAIL mis_word got=%b/%0d exp=1/0", bus.st_err, count); end
    step(1, 32'h4003, 32'h5555_6666, 2'b10, 0);
    total++; if (bus.st_err !== 1'b1 || bus.mem_valid !== 1'b0) begin bad++;
      $display("FAIL mis_b2b got=%b/%b exp=1/0", bus.st_err, bus.mem_valid); end
    step(0, 0, 0, 0, 0);
    total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL mis_end got=%b exp=0", bus.st_err); end
  endtask

  task automatic test_full();
    step(1, 32'h5000, 32'hAAAA_0001, 2'b00, 0);
    step(1, 32'h5004, 32'hBBBB_0002, 2'b00, 0);
    total++; if (bus.st_ready !== 1'b0 || count !== 2) begin bad++;
      $display("FAIL full_ready got=%b/%0d exp=0/2", bus.st_ready, count); end
    step(1, 32'h5008, 32'hCCCC_0003, 2'b00, 0);
    total++; if (count !== 2 || bus.mem_addr !== 32'h5000 || bus.mem_wdata !== 32'hAAAA_0001) begin bad++;
      $display("FAIL full_hold got=%0d/%h/%h exp=2/5000/aaaa0001", count, bus.mem_addr, bus.mem_wdata); end
    step(1, 32'h5008, 32'hCCCC_0003, 2'b00, 1);
    total++; if (count !== 1 || bus.mem_addr !== 32'h5004) begin bad++;
      $display("FAIL full_pop_no_push got=%0d/%h exp=1/5004", count, bus.mem_addr); end
    step(1, 32'h5008, 32'hCCCC_0003, 2'b00, 1);
    total++; if (count !== 1 || bus.mem_addr !== 32'h5008 || bus.mem_wdata !== 32'hCCCC_0003) begin bad++;
      $display("FAIL full_third got=%0d/%h/%h exp=1/5008/cccc0003", count, bus.mem_addr, bus.mem_wdata); end
    step(0, 0, 0, 0, 1);
    total++; if (count !== 0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  sz;
    step(1, 32'h6000, $urandom, 2'b00, 0);
    for (int i = 0; i < 6; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'h6000 + 32'(4 * (i + 1));
      if (sz == 2'b11) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'b01) a[1] = 1'($urandom_range(0, 1));
      step(1, a, $urandom, sz, 1);
      total++; if (count !== 1 || bus.mem_valid !== 1'b1) begin bad++;
        $display("FAIL b2b_count it=%0d got=%0d/%b exp=1/1", i, count, bus.mem_valid); end
      total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {q[0].addr, q[0].wdata, q[0].be}) begin bad++;
        $display("FAIL b2b_head it=%0d got=%h/%h/%b exp=%h/%h/%b", i, bus.mem_addr, bus.mem_wdata,
                 bus.mem_be, q[0].addr, q[0].wdata, q[0].be); end
    end
    step(0, 0, 0, 0, 1);
    total++; if (count !== 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    step(1, 32'h7000, 32'h0101_0101, 2'b00, 0);
    step(1, 32'h7001, 32'h0202_0202, 2'b01, 0);
    total++; if (bus.st_err !== 1'b1 || count !== 1) begin bad++;
      $display("FAIL rst_pre_err got=%b/%0d exp=1/1", bus.st_err, count); end
    #2 resetn = 1'b0;
    #1;
    total++; if (bus.st_err !== 1'b0 || count !== 0) begin bad++;
      $display("FAIL rst_err_clear got=%b/%0d exp=0/0", bus.st_err, count); end
    @(posedge clk); #1 resetn = 1'b1;
    q.delete(); err_exp = 1'b0;
    step(1, 32'h7100, 32'h0303_0303, 2'b00, 0);
    step(1, 32'h7104, 32'h0404_0404, 2'b00, 0);
    total++; if (count !== 2 || bus.mem_valid !== 1'b1) begin bad++;
      $display("FAIL rst_pre_fill got=%0d/%b exp=2/1", count, bus.mem_valid); end
    #2 resetn = 1'b0;
    #1;
    total++; if (count !== 0 || bus.mem_valid !== 1'b0 || {bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin bad++;
      $display("FAIL rst_async got=%0d/%b/%h/%h/%b exp=0/0/0/0/0", count, bus.mem_valid,
               bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    @(posedge clk); #1 resetn = 1'b1;
    q.delete(); err_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      total++; if (bus.mem_valid !== 1'b0 || count !== 0) begin bad++;
        $display("FAIL rst_stale it=%0d got=%b/%0d exp=0/0", i, bus.mem_valid, count); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    exp_t h;
    int   errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b11) a[1:0] = 2'b00;
      end
      step($urandom_range(0, 3) != 0, a, $urandom, sz, $urandom_range(0, 2) != 0);
      h = '{addr: 32'h0, wdata: 32'h0, be: 4'h0};
      if (q.size() != 0) h = q[0];
      total++;
      if (int'(count) != q.size() || bus.mem_valid !== (q.size() != 0) ||
          bus.st_ready !== (q.size() < DEPTH) || bus.st_err !== err_exp ||
          {bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {h.addr, h.wdata, h.be}) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand it=%0d got cnt=%0d v=%b rdy=%b err=%b %h/%h/%b exp cnt=%0d err=%b %h/%h/%b",
                   i, count, bus.mem_valid, bus.st_ready, bus.st_err, bus.mem_addr, bus.mem_wdata,
                   bus.mem_be, q.size(), err_exp, h.addr, h.wdata, h.be);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_word();
    test_misaligned();
    test_full();
    test_back_to_back();
    test_reset_mid();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
